// File: rtl/stopwatch_10hz_pkg.sv
// Shared constants, FSM state encoding and the BCD time-value type for the 10 Hz stopwatch.
package stopwatch_10hz_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX9 = 4'd9;
    localparam bcd_t DIGIT_MAX5 = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
        bcd_t tenth;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;

endpackage

// File: rtl/stopwatch_10hz_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, stable-time debounce and a
// single-cycle pulse on each debounced press.
module btn_cond
    import stopwatch_10hz_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The count only survives while the synchronized level keeps disagreeing.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_10hz.sv
// Tenth-of-second MM:SS.t BCD stopwatch driven by a sampled 10 Hz wave, with
// start/stop, lap-hold and clear buttons; display registers feed the LCD formatter.
module stopwatch_10hz
    import stopwatch_10hz_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             btn_ss,
    input  logic             btn_lap,
    input  logic             btn_clr,
    output logic [BCD_W-1:0] d_min_t,
    output logic [BCD_W-1:0] d_min_o,
    output logic [BCD_W-1:0] d_sec_t,
    output logic [BCD_W-1:0] d_sec_o,
    output logic [BCD_W-1:0] d_tenth,
    output logic             running,
    output logic             lap_hold,
    output logic             ovf,
    output logic             upd
);

    logic      tsync1_q, tsync2_q, thist_q;
    logic      tick_p;
    logic      ss_p, lap_p, clr_p;

    sw_state_e state_q, state_d;
    sw_time_t  live_q, live_d, live_inc;
    sw_time_t  disp_q, disp_d;
    logic      wrap;
    logic      ovf_q, ovf_d;
    logic      hold_q, hold_d;
    logic      upd_q, upd_d;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_ss),
        .press_o(ss_p)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_lap),
        .press_o(lap_p)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_clr),
        .press_o(clr_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tsync1_q <= 1'b0;
            tsync2_q <= 1'b0;
            thist_q  <= 1'b0;
        end else begin
            tsync1_q <= tick_in;
            tsync2_q <= tsync1_q;
            thist_q  <= tsync2_q;
        end
    end

    assign tick_p = tsync2_q & ~thist_q;

    // Ripple the BCD carry from tenths up to minutes tens; wrap flags 59:59.9 -> 00:00.0.
    always_comb begin
        live_inc = live_q;
        wrap     = 1'b0;
        if (live_q.tenth != DIGIT_MAX9) begin
            live_inc.tenth = live_q.tenth + 1'b1;
        end else begin
            live_inc.tenth = '0;
            if (live_q.sec_o != DIGIT_MAX9) begin
                live_inc.sec_o = live_q.sec_o + 1'b1;
            end else begin
                live_inc.sec_o = '0;
                if (live_q.sec_t != DIGIT_MAX5) begin
                    live_inc.sec_t = live_q.sec_t + 1'b1;
                end else begin
                    live_inc.sec_t = '0;
                    if (live_q.min_o != DIGIT_MAX9) begin
                        live_inc.min_o = live_q.min_o + 1'b1;
                    end else begin
                        live_inc.min_o = '0;
                        if (live_q.min_t != DIGIT_MAX5) begin
                            live_inc.min_t = live_q.min_t + 1'b1;
                        end else begin
                            live_inc.min_t = '0;
                            wrap           = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Counting and lap decisions use the current state, so a tick landing with
    // the stop press is still counted and the state change shows next cycle.
    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        if (clr_p) begin
            state_d = ST_IDLE;
            live_d  = TIME_ZERO;
            ovf_d   = 1'b0;
            hold_d  = 1'b0;
        end else begin
            if (ss_p) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end
            if (tick_p && state_q == ST_RUN) begin
                live_d = live_inc;
                if (wrap) begin
                    ovf_d = 1'b1;
                end
            end
            if (lap_p) begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (state_q == ST_RUN) begin
                    hold_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        disp_d = hold_q ? disp_q : live_q;
        upd_d  = (disp_d != disp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            live_q  <= TIME_ZERO;
            disp_q  <= TIME_ZERO;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            upd_q   <= upd_d;
        end
    end

    assign d_min_t  = disp_q.min_t;
    assign d_min_o  = disp_q.min_o;
    assign d_sec_t  = disp_q.sec_t;
    assign d_sec_o  = disp_q.sec_o;
    assign d_tenth  = disp_q.tenth;
    assign running  = (state_q == ST_RUN);
    assign lap_hold = hold_q;
    assign ovf      = ovf_q;
    assign upd      = upd_q;

endmodule

// File: tb/tb_stopwatch_10hz.sv
// Self-checking bench for stopwatch_10hz: scenario tasks plus a randomized run
// compared against a tenths-of-a-second arithmetic model of the stopwatch.
module tb_stopwatch_10hz;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick_in = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] d_min_t, d_min_o, d_sec_t, d_sec_o, d_tenth;
    logic       running, lap_hold, ovf, upd;
    logic [19:0] dispView;

    int testsRun = 0;
    int testsFailed = 0;
    int updSeen = 0;

    // Model: elapsed tenths, 0 idle / 1 run / 2 pause, overflow, lap snapshot.
    int cntModel = 0;
    int stModel = 0;
    int snapModel = 0;
    bit ovfModel = 1'b0;
    bit holdModel = 1'b0;

    stopwatch_10hz #(.DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .btn_ss  (btn_ss),
        .btn_lap (btn_lap),
        .btn_clr (btn_clr),
        .d_min_t (d_min_t),
        .d_min_o (d_min_o),
        .d_sec_t (d_sec_t),
        .d_sec_o (d_sec_o),
        .d_tenth (d_tenth),
        .running (running),
        .lap_hold(lap_hold),
        .ovf     (ovf),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    assign dispView = {d_min_t, d_min_o, d_sec_t, d_sec_o, d_tenth};

    always @(negedge clk) begin
        if (upd === 1'b1) updSeen++;
    end

    function automatic logic [19:0] expDigits(input int t);
        int m;
        int s;
        m = t / 600;
        s = (t / 10) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    function automatic logic [19:0] expDisplay();
        return expDigits(holdModel ? snapModel : cntModel);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        cntModel = 0;
        stModel = 0;
        snapModel = 0;
        ovfModel = 1'b0;
        holdModel = 1'b0;
    endtask

    task automatic applyTick(input int hi, input int lo);
        tick_in = 1'b1;
        repeat (hi) @(negedge clk);
        tick_in = 1'b0;
        repeat (lo) @(negedge clk);
        if (stModel == 1) begin
            cntModel++;
            if (cntModel == 36000) begin
                cntModel = 0;
                ovfModel = 1'b1;
            end
        end
    endtask

    // mask bit0 = start/stop, bit1 = lap, bit2 = clear
    task automatic applyPress(input logic [2:0] mask);
        btn_ss = mask[0];
        btn_lap = mask[1];
        btn_clr = mask[2];
        idle(10);
        btn_ss = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        idle(12);
        if (mask[2]) begin
            stModel = 0;
            cntModel = 0;
            ovfModel = 1'b0;
            holdModel = 1'b0;
        end else begin
            if (mask[1]) begin
                if (holdModel) begin
                    holdModel = 1'b0;
                end else if (stModel == 1) begin
                    holdModel = 1'b1;
                    snapModel = cntModel;
                end
            end
            if (mask[0]) stModel = (stModel == 1) ? 2 : 1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        idle(2);
        modelReset();
        testsRun++;
        if (dispView !== 20'h00000) begin
            testsFailed++;
            $display("[TB] FAIL reset_display: got %h expected %h", dispView, 20'h00000);
        end
        testsRun++;
        if ({running, lap_hold, ovf, upd} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {running, lap_hold, ovf, upd});
        end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_run_ticks();
        updSeen = 0;
        applyPress(3'b001);
        for (int i = 0; i < 25; i++) applyTick(20, 20);
        idle(4);
        testsRun++;
        if (dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL run_display: got %h expected %h", dispView, expDisplay());
        end
        testsRun++;
        if (running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL run_running: got %b expected 1", running);
        end
        testsRun++;
        if (updSeen != 25) begin
            testsFailed++;
            $display("[TB] FAIL run_upd_count: got %0d expected 25", updSeen);
        end
        testsRun++;
        if (ovf !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL run_ovf: got %b expected 0", ovf);
        end
    endtask

    task automatic test_overflow();
        applyPress(3'b100);
        applyPress(3'b001);
        for (int i = 0; i < 35999; i++) applyTick(1, 1);
        idle(4);
        testsRun++;
        if (dispView !== expDisplay() || ovf !== ovfModel) begin
            testsFailed++;
            $display("[TB] FAIL ovf_preload: got %h/%b expected %h/%b", dispView, ovf, expDisplay(), ovfModel);
        end
        applyTick(1, 1);
        idle(4);
        testsRun++;
        if (dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL ovf_wrap_display: got %h expected %h", dispView, expDisplay());
        end
        testsRun++;
        if (ovf !== 1'b1 || running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ovf_wrap_flags: got ovf=%b running=%b expected ovf=1 running=1", ovf, running);
        end
        applyPress(3'b100);
        testsRun++;
        if (ovf !== 1'b0 || running !== 1'b0 || dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL ovf_clear: got ovf=%b running=%b disp=%h expected 0 0 %h", ovf, running, dispView, expDisplay());
        end
    endtask

    task automatic test_lap();
        bit seen;
        logic [19:0] snapExp;
        applyPress(3'b100);
        applyPress(3'b001);
        for (int i = 0; i < 10; i++) applyTick($urandom_range(3, 20), $urandom_range(3, 20));
        applyPress(3'b010);
        snapExp = expDisplay();
        for (int i = 0; i < 12; i++) applyTick($urandom_range(3, 20), $urandom_range(3, 20));
        idle(4);
        testsRun++;
        if (dispView !== snapExp || lap_hold !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lap_frozen: got %h hold=%b expected %h hold=1", dispView, lap_hold, snapExp);
        end
        btn_lap = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (lap_hold === 1'b0) seen = 1'b1;
        end
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("[TB] FAIL lap_release_timeout: got hold=%b expected 0 within 30 cycles", lap_hold);
        end
        holdModel = 1'b0;
        if (seen) begin
            testsRun++;
            if (dispView !== snapExp) begin
                testsFailed++;
                $display("[TB] FAIL lap_release_same_cycle: got %h expected %h", dispView, snapExp);
            end
            @(negedge clk);
            testsRun++;
            if (dispView !== expDisplay() || upd !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL lap_reload: got %h upd=%b expected %h upd=1", dispView, upd, expDisplay());
            end
        end
        btn_lap = 1'b0;
        idle(12);
    endtask

    task automatic test_stop_coincide();
        applyPress(3'b100);
        applyPress(3'b001);
        for (int i = 0; i < int'($urandom_range(1, 15)); i++) applyTick(4, 4);
        // Raw press at N0 debounces to a pulse that lines up with a tick raised 4 cycles later.
        btn_ss = 1'b1;
        idle(4);
        tick_in = 1'b1;
        idle(6);
        btn_ss = 1'b0;
        idle(14);
        tick_in = 1'b0;
        idle(20);
        cntModel++;
        stModel = 2;
        testsRun++;
        if (dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL coincide_counted: got %h expected %h", dispView, expDisplay());
        end
        testsRun++;
        if (running !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL coincide_paused: got running=%b expected 0", running);
        end
        for (int i = 0; i < 5; i++) applyTick(5, 5);
        idle(4);
        testsRun++;
        if (dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL pause_no_count: got %h expected %h", dispView, expDisplay());
        end
    endtask

    task automatic test_glitch_and_priority();
        applyPress(3'b100);
        applyPress(3'b001);
        for (int i = 0; i < 7; i++) applyTick(4, 4);
        for (int i = 0; i < 15; i++) begin
            btn_ss = ~btn_ss;
            idle(2);
        end
        btn_ss = 1'b0;
        idle(12);
        testsRun++;
        if (running !== 1'b1 || dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL glitch_ignored: got running=%b disp=%h expected 1 %h", running, dispView, expDisplay());
        end
        applyPress(3'b101);
        testsRun++;
        if (running !== 1'b0 || dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL clr_priority: got running=%b disp=%h expected 0 %h", running, dispView, expDisplay());
        end
    endtask

    task automatic test_async_reset();
        applyPress(3'b100);
        applyPress(3'b001);
        for (int i = 0; i < 73; i++) applyTick($urandom_range(3, 6), $urandom_range(3, 6));
        idle(4);
        testsRun++;
        if (dispView !== expDisplay()) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset_display: got %h expected %h", dispView, expDisplay());
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        testsRun++;
        if (dispView !== 20'h00000 || {running, lap_hold, ovf, upd} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got %h flags=%b expected 00000 flags=0000", dispView, {running, lap_hold, ovf, upd});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyTick(5, 5);
        idle(4);
        testsRun++;
        if (dispView !== expDisplay() || running !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_idle: got %h running=%b expected %h running=0", dispView, running, expDisplay());
        end
        applyPress(3'b001);
        for (int i = 0; i < 3; i++) applyTick(5, 5);
        idle(4);
        testsRun++;
        if (dispView !== expDisplay() || running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_resume: got %h running=%b expected %h running=1", dispView, running, expDisplay());
        end
    endtask

    task automatic test_random_ops();
        int op;
        applyPress(3'b100);
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) applyTick($urandom_range(3, 20), $urandom_range(3, 20));
            else if (op <= 7) applyPress(3'b001);
            else if (op == 8) applyPress(3'b010);
            else applyPress(3'b100);
            idle(4);
            testsRun++;
            if (dispView !== expDisplay()) begin
                testsFailed++;
                $display("[TB] FAIL rand_display op%0d: got %h expected %h", n, dispView, expDisplay());
            end
            testsRun++;
            if (running !== (stModel == 1) || lap_hold !== holdModel || ovf !== ovfModel) begin
                testsFailed++;
                $display("[TB] FAIL rand_flags op%0d: got run=%b hold=%b ovf=%b expected run=%b hold=%b ovf=%b",
                         n, running, lap_hold, ovf, (stModel == 1), holdModel, ovfModel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_overflow();
        test_lap();
        test_stop_coincide();
        test_glitch_and_priority();
        test_async_reset();
        test_random_ops();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
